// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvMixColumns block.
//   state_t  : controller states (IDLE, RUN, DONE)
//   AES_POLY : low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
//   COL_W    : width of one state column in bits
//   xtime    : multiply a field element by {02}
//   gf_mul   : general GF(2^8) product, built from an xtime chain
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  AES_POLY = 8'h1B;
  localparam int unsigned COL_W    = 32;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_col32.sv
// Combinational InvMixColumns transform of a single 32-bit column.
//   i_col : input column, byte s0 in bits [31:24] down to s3 in bits [7:0]
//   o_col : output column, same byte order
// r_i = {0e}s_i ^ {0b}s_(i+1) ^ {0d}s_(i+2) ^ {09}s_(i+3), indices mod 4.
module inv_mix_col32
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  output logic [COL_W-1:0] o_col
);

  // Each constant is decomposed into {02},{04},{08} terms from one xtime chain.
  function automatic logic [7:0] mul09(input logic [7:0] b);
    logic [7:0] b8;
    b8 = xtime(xtime(xtime(b)));
    return b8 ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    logic [7:0] b2;
    logic [7:0] b8;
    b2 = xtime(b);
    b8 = xtime(xtime(b2));
    return b8 ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    logic [7:0] b4;
    logic [7:0] b8;
    b4 = xtime(xtime(b));
    b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    logic [7:0] b2;
    logic [7:0] b4;
    logic [7:0] b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

  function automatic logic [7:0] inv_byte(input logic [7:0] p0, input logic [7:0] p1,
                                          input logic [7:0] p2, input logic [7:0] p3);
    return mul0e(p0) ^ mul0b(p1) ^ mul0d(p2) ^ mul09(p3);
  endfunction

  logic [7:0] w_s0;
  logic [7:0] w_s1;
  logic [7:0] w_s2;
  logic [7:0] w_s3;

  always_comb begin
    w_s0  = i_col[31:24];
    w_s1  = i_col[23:16];
    w_s2  = i_col[15:8];
    w_s3  = i_col[7:0];
    o_col = {inv_byte(w_s0, w_s1, w_s2, w_s3),
             inv_byte(w_s1, w_s2, w_s3, w_s0),
             inv_byte(w_s2, w_s3, w_s0, w_s1),
             inv_byte(w_s3, w_s0, w_s1, w_s2)};
  end

endmodule

// File: rtl/inv_mixcolumn.sv
// Sequential InvMixColumns over a full AES state, one column per cycle.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : request pulse, sampled only in IDLE
//   a      : input state, column 0 in the MSBs, byte 0 of each column in its MSB byte
//   imcl   : registered result, same layout as a; updated column by column during RUN
//   busy   : high whenever the controller is not in IDLE
//   finish : one-cycle pulse (DONE state) marking imcl valid
// Timing: start seen at edge 0, column k written at edge k+1, finish in the cycle after edge NCOL.
module inv_mixcolumn
  import aes_pkg::*;
#(
  parameter int NCOL = 4
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NCOL*COL_W-1:0] a,
  output logic [NCOL*COL_W-1:0] imcl,
  output logic                  busy,
  output logic                  finish
);

  localparam int unsigned    CNT_W    = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCOL - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [NCOL*COL_W-1:0]   r_a;
  logic [NCOL*COL_W-1:0]   r_imcl;
  logic [COL_W-1:0]        w_col_in;
  logic [COL_W-1:0]        w_col_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and status outputs; finish/busy depend on state only,
  // so start never reaches finish combinationally.
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    finish = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = RUN;
      end
      RUN: begin
        if (r_cnt == LAST_CNT) w_next = DONE;
      end
      DONE: begin
        finish = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // Column select feeding the single shared transform.
  always_comb begin
    w_col_in = '0;
    for (int unsigned k = 0; k < NCOL; k++) begin
      if (r_cnt == CNT_W'(k)) w_col_in = r_a[(NCOL - 1 - k) * COL_W +: COL_W];
    end
  end

  inv_mix_col32 u_col (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  // Datapath: input latch, column counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_cnt  <= '0;
      r_imcl <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_cnt <= '0;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < NCOL; k++) begin
            if (r_cnt == CNT_W'(k)) r_imcl[(NCOL - 1 - k) * COL_W +: COL_W] <= w_col_out;
          end
          r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign imcl = r_imcl;

endmodule

// File: tb/tb_inv_mixcolumn.sv
module tb_inv_mixcolumn;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] a;
  logic [127:0] imcl;
  logic         busy;
  logic         finish;

  always #5 clk = ~clk;

  inv_mixcolumn #(.NCOL(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .imcl   (imcl),
    .busy   (busy),
    .finish (finish)
  );

  typedef struct {
    logic [127:0] exp;
    longint       due;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_finish = 0;

  // Reference: polynomial product then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'(x) << i);
    for (int b = 14; b >= 8; b--) if (p[b]) p = p ^ (16'h011B << (b - 8));
    return p[7:0];
  endfunction

  // MixColumns (inverse=0) or InvMixColumns (inverse=1) of a whole state.
  function automatic logic [127:0] mix_model(input logic [127:0] st, input bit inverse);
    logic [7:0]   c [4];
    logic [7:0]   k [4];
    logic [7:0]   acc;
    logic [127:0] r;
    r = '0;
    if (inverse) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         k = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int col = 0; col < 4; col++) begin
      for (int i = 0; i < 4; i++) c[i] = st[127 - 32*col - 8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[j], c[2'((i + j) % 4)]);
        r[127 - 32*col - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  // Monitor: every finish pulse must match the oldest outstanding request,
  // both in value and in the cycle it was predicted for.
  always @(negedge clk) begin
    if (finish === 1'b1) begin
      if (sb.size() == 0) begin
        flag("unexpected_finish", "finish=1, required 0 (no request pending)");
      end else begin
        mon_e = sb.pop_front();
        n_finish++;
        chk("imcl_result", imcl, mon_e.exp);
        chk("finish_time", 128'($time), 128'(mon_e.due));
      end
    end else if (sb.size() > 0 && sb[0].due < longint'($time)) begin
      mon_e = sb.pop_front();
      flag("missing_finish", $sformatf("no finish by %0d, required at %0d", $time, mon_e.due));
    end
  end

  task automatic push_exp(input logic [127:0] ex);
    sb_t ent;
    ent.exp = ex;
    ent.due = longint'($time) + 50;
    sb.push_back(ent);
  endtask

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic issue(input logic [127:0] av, input logic [127:0] ex);
    a     = av;
    start = 1'b1;
    push_exp(ex);
    @(negedge clk);
    start = 1'b0;
    a     = rnd128();
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy === 1'b0) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) flag(name, "busy did not return to 0 within 20 cycles");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] A28 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] E28 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] A29 = 128'h4d7ebdf8_c6c6c6c6_00000000_ffffffff;
  localparam logic [127:0] E29 = 128'h2d26314c_c6c6c6c6_00000000_ffffffff;

  initial begin
    logic [127:0] s;
    logic [127:0] s2;
    logic [127:0] part;
    int           fin0;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;

    #1;
    chk("reset_imcl",   imcl,          '0);
    chk("reset_busy",   128'(busy),    '0);
    chk("reset_finish", 128'(finish),  '0);
    start = 1'b1;
    a     = rnd128();
    repeat (2) @(negedge clk);
    chk("reset_hold_imcl", imcl,       '0);
    chk("reset_hold_busy", 128'(busy), '0);
    start = 1'b0;
    rst   = 1'b0;

    // Single-column vector, issued right after reset release.
    issue(A29, E29);
    wait_idle("idle_after_vec29");
    @(negedge clk);
    chk("hold_after_done", imcl, E29);

    // Full-state vector with per-cycle partial-update checks.
    a     = A28;
    start = 1'b1;
    push_exp(E28);
    @(negedge clk);
    start = 1'b0;
    a     = rnd128();
    chk("busy_run", 128'(busy), 128'(1'b1));
    chk("partial_none", imcl, E29);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++)
        part[127 - 32*c -: 32] = (c <= k) ? E28[127 - 32*c -: 32] : E29[127 - 32*c -: 32];
      chk($sformatf("partial_col%0d", k), imcl, part);
    end
    @(negedge clk);
    chk("busy_idle", 128'(busy), '0);
    chk("hold_vec28", imcl, E28);

    // Random states against the inverse model.
    for (int i = 0; i < 20; i++) begin
      s = rnd128();
      issue(s, mix_model(s, 1'b1));
      wait_idle("idle_random");
    end

    // Round trip: forward model output fed in, original state expected.
    for (int i = 0; i < 1000; i++) begin
      s = rnd128();
      issue(mix_model(s, 1'b0), s);
      wait_idle("idle_roundtrip");
    end

    // Start re-pulsed during RUN (cycle 2) and DONE (cycle 5) with another input.
    fin0 = n_finish;
    s    = rnd128();
    s2   = ~s;
    a     = s;
    start = 1'b1;
    push_exp(mix_model(s, 1'b1));
    @(negedge clk); start = 1'b0; a = s2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_done_start", 128'(busy), '0);
    repeat (8) @(negedge clk);
    chk("busy_start_finish_count", 128'(n_finish - fin0), 128'(1));

    // Reset in the middle of RUN aborts without a finish pulse.
    fin0 = n_finish;
    s    = rnd128();
    a     = s;
    start = 1'b1;
    push_exp(mix_model(s, 1'b1));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    void'(sb.pop_back());
    rst = 1'b1;
    #1;
    chk("midrst_imcl",   imcl,         '0);
    chk("midrst_busy",   128'(busy),   '0);
    chk("midrst_finish", 128'(finish), '0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_finish", 128'(n_finish - fin0), '0);
    s = rnd128();
    issue(s, mix_model(s, 1'b1));
    wait_idle("idle_after_midrst");

    // Start held high for 18 cycles with a changing every cycle;
    // requests are taken on cycles 0, 6 and 12.
    fin0 = n_finish;
    for (int cyc = 0; cyc < 18; cyc++) begin
      s     = rnd128();
      a     = s;
      start = 1'b1;
      if (cyc % 6 == 0) push_exp(mix_model(s, 1'b1));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle("idle_after_continuous");
    repeat (2) @(negedge clk);
    chk("continuous_finish_count", 128'(n_finish - fin0), 128'(3));

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 128'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_mixcolumn.md
INV_MIXCOLUMN -- requirements
Module: inv_mixcolumn

Interface
REQ-001 The block SHALL provide parameter NCOL, default 4, meaning the number of 32-bit columns per 128-bit AES state.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset; asynchronous, active-high.
REQ-004 start  input  1  Request pulse; sampled only while the FSM is in IDLE.
REQ-005 a  input  128  Input state; column 0 = a[127:96], byte 0 of each column in its MSB byte.
REQ-006 imcl  output  128  InvMixColumns result, registered, with the same byte and column layout as a.
REQ-007 busy  output  1  High whenever the FSM is not in IDLE.
REQ-008 finish  output  1  One-cycle pulse marking imcl valid for the latched request.

Function
REQ-009 FSM SHALL have the states IDLE, RUN and DONE.
- IDLE to RUN on start=1.
- RUN to DONE after the column-3 cycle.
- DONE to IDLE unconditionally.
REQ-010 On start in IDLE, the block SHALL latch a into an internal 128-bit register and clear the column counter to 0.
REQ-011 In RUN, the block SHALL transform one column per cycle, in order 0,1,2,3, selected by a 2-bit counter, writing the result into the matching 32-bit slice of imcl.
REQ-012 Column transform, for input bytes s0..s3 and output bytes r0..r3: r_i = 0e*s_i ^ 0b*s_(i+1) ^ 0d*s_(i+2) ^ 09*s_(i+3), indices mod 4.
REQ-013 Multiplication in REQ-012 SHALL be over GF(2^8) with polynomial 0x11B, built from xtime chains; all intermediates are 8 bits wide with no carry-out.
REQ-014 Latency SHALL be fixed: start sampled at edge 0, column k written at edge k+1, finish high for exactly the cycle after edge 4.
REQ-015 finish SHALL be high only in DONE, and SHALL be high in DONE exactly once per accepted start.
REQ-016 start asserted while busy=1, including the DONE cycle, SHALL be ignored with no effect on the latched input, counter or imcl.
REQ-017 start held high continuously SHALL produce back-to-back operations, with one new request accepted each time the FSM is in IDLE: one accepted start every 6 cycles.
REQ-018 Changes on a after start is accepted SHALL NOT affect the running result.
REQ-019 imcl SHALL hold its value from the last completed operation until overwritten column-by-column by the next operation; partial updates are visible during RUN.
REQ-020 The counter SHALL wrap 3 to 0 on the RUN-to-DONE transition.

Reset
REQ-021 While rst=1, the FSM SHALL be IDLE, with counter=0, latched input=0, imcl=128'h0, busy=0 and finish=0.
REQ-022 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately, without producing a finish pulse.
REQ-023 After rst deasserts, the first start SHALL be accepted in the first clock cycle.

Structure
REQ-024 Package aes_pkg SHALL hold:
- the FSM state enum;
- AES_POLY = 8'h1B;
- the column-width constant (32);
- the GF helper functions xtime and gf_mul.
REQ-025 One combinational sub-module, inv_mix_col32, SHALL implement REQ-012 for one 32-bit column.
REQ-026 inv_mix_col32 SHALL be instantiated once and time-shared across the four columns via the counter-driven mux.
REQ-027 The RTL SHALL contain no latches and no combinational path from start to finish.

Verification
REQ-028 Full-state test: a=8e4da1bc_9fdc589d_01010101_d5d5d7d6 with a start pulse -> finish on cycle 5, imcl=db135345_f20a225c_01010101_d4d4d4d5.
REQ-029 Single-column test: a=4d7ebdf8_c6c6c6c6_00000000_ffffffff -> imcl=2d26314c_c6c6c6c6_00000000_ffffffff.
REQ-030 Round trip: 1000 random 128-bit states passed through mixcolumn, then through this block -> imcl equals the original state each time.
REQ-031 Busy-start test: start re-pulsed on cycles 2 and 5 with a different a -> exactly one finish pulse, and the result matches the first a.
REQ-032 Mid-operation reset: rst asserted on cycle 3 -> imcl=0, busy=0, no finish pulse; the next start completes correctly.
REQ-033 Continuous start: start held high for 18 cycles -> exactly 3 finish pulses, spaced 6 cycles apart.
